// File: rtl/dp_sequencer_pkg.sv
// Shared definitions for the data_path micro-sequencer: microword layout,
// FSM state encoding and ALU opcode constants.
package dp_sequencer_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_PASS = 4'd6;

    // Field order fixes the bit positions: last is bit 15, wait_dp is bit 0.
    typedef struct packed {
        logic       last;
        logic [3:0] opcode;
        logic [2:0] dest;
        logic [2:0] src1;
        logic [2:0] src2;
        logic       wr;
        logic       wait_dp;
    } uword_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_FINISH
    } state_t;

    function automatic uword_t mkword(input logic last, input logic [3:0] op,
                                      input logic [2:0] d, input logic [2:0] s1,
                                      input logic [2:0] s2, input logic wr,
                                      input logic wt);
        uword_t w;
        w.last    = last;
        w.opcode  = op;
        w.dest    = d;
        w.src1    = s1;
        w.src2    = s2;
        w.wr      = wr;
        w.wait_dp = wt;
        return w;
    endfunction

endpackage

// File: rtl/dp_ucode_rom.sv
// Combinational micro-op ROM and routine entry table for dp_sequencer.
module dp_ucode_rom
    import dp_sequencer_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic [PC_W-1:0] pc,
    input  logic [2:0]      c,
    output uword_t          uword,
    output logic [PC_W-1:0] entry
);

    // Unlisted locations hold an all-zero NOP without a last bit.
    always_comb begin
        uword = '0;
        case (int'(pc))
            0:  uword = mkword(1'b0, OP_ADD,  3'd3, 3'd1, 3'd2, 1'b1, 1'b0);
            1:  uword = mkword(1'b1, OP_SUB,  3'd4, 3'd3, 3'd1, 1'b1, 1'b0);
            2:  uword = mkword(1'b0, OP_AND,  3'd5, 3'd1, 3'd2, 1'b1, 1'b1);
            3:  uword = mkword(1'b1, OP_OR,   3'd6, 3'd5, 3'd4, 1'b1, 1'b0);
            4:  uword = mkword(1'b1, OP_PASS, 3'd0, 3'd7, 3'd0, 1'b0, 1'b1);
            13: uword = mkword(1'b0, OP_XOR,  3'd1, 3'd2, 3'd3, 1'b1, 1'b0);
            14: uword = mkword(1'b0, OP_ADD,  3'd2, 3'd1, 3'd1, 1'b1, 1'b0);
            15: uword = mkword(1'b0, OP_SUB,  3'd7, 3'd7, 3'd6, 1'b1, 1'b0);
            default: uword = '0;
        endcase
    end

    always_comb begin
        entry = PC_W'(0);
        case (c)
            3'd1:    entry = PC_W'(2);
            3'd2:    entry = PC_W'(13);
            3'd3:    entry = PC_W'(4);
            default: entry = PC_W'(0);
        endcase
    end

endmodule

// File: rtl/dp_sequencer.sv
// Multi-cycle micro-sequencer: launches a ROM routine on start and issues its
// micro-ops one at a time to the register-file/ALU data_path.
module dp_sequencer
    import dp_sequencer_pkg::*;
#(
    parameter int UC_DEPTH = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] c,
    input  logic       dp_done,
    output logic [2:0] src1,
    output logic [2:0] src2,
    output logic [2:0] dest,
    output logic [3:0] opcode,
    output logic       WR,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int PC_W   = $clog2(UC_DEPTH);
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(UC_DEPTH - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_MAX);

    state_t            state;
    logic [PC_W-1:0]   pc;
    uword_t            uir;
    logic [WCNT_W-1:0] wcnt;
    uword_t            rom_word;
    logic [PC_W-1:0]   entry_pc;

    dp_ucode_rom #(.PC_W(PC_W)) u_rom (
        .pc    (pc),
        .c     (c),
        .uword (rom_word),
        .entry (entry_pc)
    );

    assign src1   = uir.src1;
    assign src2   = uir.src2;
    assign dest   = uir.dest;
    assign opcode = uir.opcode;

    // WR, busy and done are registered alongside the state so each reflects the state being entered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
            pc    <= '0;
            uir   <= '0;
            wcnt  <= '0;
            err   <= 1'b0;
            WR    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            WR   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= entry_pc;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    uir   <= rom_word;
                    WR    <= rom_word.wr;
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (uir.wait_dp) begin
                        wcnt  <= '0;
                        state <= S_WAIT;
                    end else if (uir.last) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else if (pc == PC_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        pc    <= pc + 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_WAIT: begin
                    if (dp_done) begin
                        if (uir.last) begin
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else if (pc == PC_LAST) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= S_FETCH;
                        end
                    end else if (wcnt == WCNT_LAST) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// Directed self-checking bench for dp_sequencer using hand-computed expectations.
module tb_dp_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] c;
    logic       dp_done;
    logic [2:0] src1;
    logic [2:0] src2;
    logic [2:0] dest;
    logic [3:0] opcode;
    logic       WR;
    logic       busy;
    logic       done;
    logic       err;

    int checks   = 0;
    int failures = 0;

    dp_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .c       (c),
        .dp_done (dp_done),
        .src1    (src1),
        .src2    (src2),
        .dest    (dest),
        .opcode  (opcode),
        .WR      (WR),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Inputs are driven mid-cycle, take effect at the next rising edge, and outputs are then sampled on the falling edge.
    task automatic applyStimulus(input logic r, input logic s, input logic [2:0] cc, input logic d);
        rst     = r;
        start   = s;
        c       = cc;
        dp_done = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int doneCount;
        int wrCount;
        bit seen;
        rst = 1'b0; start = 1'b0; c = 3'd0; dp_done = 1'b0;
        $display("[TB] dp_sequencer directed test starting");

        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_wr", 32'(WR), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_fields", 32'({opcode, dest, src1, src2}), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);

        // Routine 0: ADD d3,s1,s2 then SUB d4,s3,s1 with last
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        checkOutput("r0_fetch_busy", 32'(busy), 32'd1);
        checkOutput("r0_fetch_wr", 32'(WR), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r0_op1_wr", 32'(WR), 32'd1);
        checkOutput("r0_op1_fields", 32'({opcode, dest, src1, src2}), 32'({4'd1, 3'd3, 3'd1, 3'd2}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r0_fetch2_wr", 32'(WR), 32'd0);
        checkOutput("r0_fetch2_hold_dest", 32'(dest), 32'd3);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r0_op2_wr", 32'(WR), 32'd1);
        checkOutput("r0_op2_fields", 32'({opcode, dest, src1, src2}), 32'({4'd2, 3'd4, 3'd3, 3'd1}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r0_finish_done", 32'(done), 32'd1);
        checkOutput("r0_finish_busy", 32'(busy), 32'd1);
        checkOutput("r0_finish_wr", 32'(WR), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r0_idle_busy", 32'(busy), 32'd0);
        checkOutput("r0_idle_done", 32'(done), 32'd0);

        // Routine 1: wait op; dp_done high in FETCH/ISSUE must not be credited
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        checkOutput("r1_issue_wr", 32'(WR), 32'd1);
        checkOutput("r1_issue_fields", 32'({opcode, dest, src1, src2}), 32'({4'd3, 3'd5, 3'd1, 3'd2}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        checkOutput("r1_wait0_wr", 32'(WR), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            checkOutput($sformatf("r1_wait%0d_wr", i + 1), 32'(WR), 32'd0);
            checkOutput($sformatf("r1_wait%0d_busy", i + 1), 32'(busy), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
        checkOutput("r1_refetch_wr", 32'(WR), 32'd0);
        checkOutput("r1_refetch_done", 32'(done), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r1_op2_wr", 32'(WR), 32'd1);
        checkOutput("r1_op2_fields", 32'({opcode, dest, src1, src2}), 32'({4'd4, 3'd6, 3'd5, 3'd4}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r1_finish_done", 32'(done), 32'd1);
        checkOutput("r1_finish_err", 32'(err), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);

        // Routine 3: wait op that never sees dp_done aborts after 16 WAIT cycles
        applyStimulus(1'b1, 1'b1, 3'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r3_issue_wr", 32'(WR), 32'd0);
        checkOutput("r3_issue_src1", 32'(src1), 32'd7);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 15; i++) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r3_wait15_done", 32'(done), 32'd0);
        checkOutput("r3_wait15_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r3_abort_done", 32'(done), 32'd1);
        checkOutput("r3_abort_err", 32'(err), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r3_idle_err_sticky", 32'(err), 32'd1);
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        checkOutput("r3_restart_err_clear", 32'(err), 32'd0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r3_restart_idle", 32'(busy), 32'd0);

        // start held high through a routine: one done, FINISH-cycle start ignored
        doneCount = 0;
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
            if (done) doneCount++;
        end
        checkOutput("hold_done_count", 32'(doneCount), 32'd1);
        checkOutput("hold_idle_after_finish", 32'(busy), 32'd0);
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        checkOutput("hold_next_accepted", 32'(busy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            if (done) seen = 1'b1;
        end
        checkOutput("hold_second_done_seen", 32'(seen), 32'd1);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);

        // Routine 2 runs off the end of the ROM without a last bit
        applyStimulus(1'b1, 1'b1, 3'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r2_op1_fields", 32'({WR, opcode, dest, src1, src2}), 32'({1'b1, 4'd5, 3'd1, 3'd2, 3'd3}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r2_op2_fields", 32'({WR, opcode, dest, src1, src2}), 32'({1'b1, 4'd1, 3'd2, 3'd1, 3'd1}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r2_op3_fields", 32'({WR, opcode, dest, src1, src2}), 32'({1'b1, 4'd2, 3'd7, 3'd7, 3'd6}));
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r2_overflow_done", 32'(done), 32'd1);
        checkOutput("r2_overflow_err", 32'(err), 32'd1);
        checkOutput("r2_overflow_wr", 32'(WR), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("r2_no_wrap_busy", 32'(busy), 32'd0);
        checkOutput("r2_no_wrap_dest", 32'(dest), 32'd7);
        checkOutput("r2_no_wrap_wr", 32'(WR), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("idle_reset_err", 32'(err), 32'd0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);

        // Reset held for two cycles in the middle of routine 0
        applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
        checkOutput("midrst_pre_wr", 32'(WR), 32'd1);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("midrst_outputs", 32'({WR, busy, done, err, opcode, dest, src1, src2}), 32'd0);
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
        checkOutput("midrst_busy2", 32'(busy), 32'd0);
        doneCount = 0;
        wrCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
            if (done) doneCount++;
            if (WR) wrCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
        checkOutput("midrst_no_wr", 32'(wrCount), 32'd0);
        checkOutput("midrst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
